// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg
//   Shared definitions for the system-control command path: the command
//   front-end FSM state encoding and the frame opcodes, which the UART-side
//   controllers also reuse.
package sys_ctrl_pkg;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        TX_SEND
    } state_e;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl
//   Decodes UART command frames and drives the register file port.
//     write frame : WR_CMD, address, data  -> one-cycle WrEn
//     read frame  : RD_CMD, address        -> one-cycle RdEn, then read data
//                                             is forwarded to the UART TX
//   Ports:
//     CLK, RST                 clock, async active-low reset
//     RX_P_Data, RX_D_VLD      received byte and its one-cycle valid
//     Address, WrEn, RdEn,
//     WrData                   register-file command port (registered)
//     RdData, RdData_Valid     register-file read return
//     TX_P_Data, TX_D_VLD      byte to transmit and one-cycle request
//     TX_Busy                  transmitter busy
//     Cmd_Err                  one-cycle pulse on bad opcode / dropped byte
module reg_cmd_ctrl #(
    parameter int                  AddWidth = 4,
    parameter int                  BusWidth = 8,
    parameter logic [BusWidth-1:0] WR_CMD   = BusWidth'(sys_ctrl_pkg::WR_CMD),
    parameter logic [BusWidth-1:0] RD_CMD   = BusWidth'(sys_ctrl_pkg::RD_CMD)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [BusWidth-1:0] RX_P_Data,
    input  logic                RX_D_VLD,
    output logic [AddWidth-1:0] Address,
    output logic                WrEn,
    output logic                RdEn,
    output logic [BusWidth-1:0] WrData,
    input  logic [BusWidth-1:0] RdData,
    input  logic                RdData_Valid,
    output logic [BusWidth-1:0] TX_P_Data,
    output logic                TX_D_VLD,
    input  logic                TX_Busy,
    output logic                Cmd_Err
);

    import sys_ctrl_pkg::*;

    state_e              state, state_n;
    logic [AddWidth-1:0] addr_n;
    logic [BusWidth-1:0] wdata_n, txdata_n;
    logic                wren_n, rden_n, txvld_n, err_n;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            Address   <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            WrData    <= '0;
            TX_P_Data <= '0;
            TX_D_VLD  <= 1'b0;
            Cmd_Err   <= 1'b0;
        end else begin
            state     <= state_n;
            Address   <= addr_n;
            WrEn      <= wren_n;
            RdEn      <= rden_n;
            WrData    <= wdata_n;
            TX_P_Data <= txdata_n;
            TX_D_VLD  <= txvld_n;
            Cmd_Err   <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = Address;
        wdata_n  = WrData;
        txdata_n = TX_P_Data;
        wren_n   = 1'b0;
        rden_n   = 1'b0;
        txvld_n  = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_Data == WR_CMD)      state_n = WR_ADDR;
                    else if (RX_P_Data == RD_CMD) state_n = RD_ADDR;
                    else                          err_n   = 1'b1;
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n  = RX_P_Data[AddWidth-1:0];
                    state_n = WR_DATA;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    wdata_n = RX_P_Data;
                    wren_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_n  = RX_P_Data[AddWidth-1:0];
                    rden_n  = 1'b1;
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                err_n = RX_D_VLD;
                // While RdEn is still high the valid flag can be left over
                // from the previous read, so it is only trusted afterwards.
                if (RdData_Valid && !RdEn) begin
                    txdata_n = RdData;
                    // TX_Busy is already sampled in the capture cycle so an
                    // idle transmitter gets its request one cycle after the
                    // capture; otherwise wait in TX_SEND.
                    if (!TX_Busy) begin
                        txvld_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = TX_SEND;
                    end
                end
            end
            TX_SEND: begin
                err_n = RX_D_VLD;
                if (!TX_Busy) begin
                    txvld_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
module tb_reg_cmd_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] RX_P_Data;
    logic       RX_D_VLD;
    logic [3:0] Address;
    logic       WrEn, RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData = 8'h00;
    logic       RdData_Valid = 1'b0;
    logic [7:0] TX_P_Data;
    logic       TX_D_VLD;
    logic       TX_Busy;
    logic       Cmd_Err;

    reg_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy),
        .Cmd_Err(Cmd_Err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // register file model: 1-cycle read latency, valid optionally sticky
    logic [7:0] mem [16];
    logic       hold = 1'b0;
    always @(posedge CLK) begin
        if (WrEn) mem[Address] <= WrData;
        RdData_Valid <= RdEn | (hold & RdData_Valid);
        if (RdEn) RdData <= mem[Address];
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t wr_q[$], rd_q[$], tx_q[$], err_q[$];
    logic [7:0] exp_mem [16];
    int passed = 0;
    int total  = 0;

    function automatic ev_t mk(input logic [7:0] a, input logic [7:0] d, input int c);
        ev_t e;
        e.addr = a; e.data = d; e.cyc = c;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard: every output strobe must match the head of its queue
    always @(negedge CLK) begin
        if (RST) begin
            ev_t e;
            if (WrEn | RdEn) check("wr_rd_excl", {31'b0, WrEn & RdEn}, 0);
            if (WrEn) begin
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", {28'b0, Address}, {24'b0, e.addr});
                    check("wr_data", {24'b0, WrData}, {24'b0, e.data});
                    check("wr_cyc", cyc, e.cyc);
                end
            end
            if (RdEn) begin
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    check("rd_addr", {28'b0, Address}, {24'b0, e.addr});
                    check("rd_cyc", cyc, e.cyc);
                end
            end
            if (TX_D_VLD) begin
                if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else begin
                    e = tx_q.pop_front();
                    check("tx_data", {24'b0, TX_P_Data}, {24'b0, e.data});
                    check("tx_cyc", cyc, e.cyc);
                end
            end
            if (Cmd_Err) begin
                if (err_q.size() == 0) check("err_unexpected", 1, 0);
                else begin
                    e = err_q.pop_front();
                    check("err_cyc", cyc, e.cyc);
                end
            end
        end
    end

    // drive one byte for one cycle; caller sits just after a posedge
    task automatic send_byte(input logic [7:0] b);
        RX_P_Data = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
        int n;
        send_byte(8'hAA);
        send_byte(a);
        n = cyc;
        send_byte(d);
        wr_q.push_back(mk({4'h0, a[3:0]}, d, n + 1));
        exp_mem[a[3:0]] = d;
    endtask

    task automatic rd_frame(input logic [7:0] a, input bit busy);
        int n;
        send_byte(8'hBB);
        n = cyc;
        send_byte(a);
        rd_q.push_back(mk({4'h0, a[3:0]}, 8'h00, n + 1));
        if (!busy) tx_q.push_back(mk(8'h00, exp_mem[a[3:0]], n + 3));
    endtask

    task automatic bad_byte(input logic [7:0] b);
        int n;
        n = cyc;
        send_byte(b);
        err_q.push_back(mk(8'h00, 8'h00, n + 1));
    endtask

    initial begin
        int m;
        RST = 1'b0; RX_P_Data = 8'h00; RX_D_VLD = 1'b0; TX_Busy = 1'b0;
        @(posedge CLK); #1;
        check("rst_address", {28'b0, Address}, 0);
        check("rst_wren", {31'b0, WrEn}, 0);
        check("rst_rden", {31'b0, RdEn}, 0);
        check("rst_wrdata", {24'b0, WrData}, 0);
        check("rst_txdata", {24'b0, TX_P_Data}, 0);
        check("rst_txvld", {31'b0, TX_D_VLD}, 0);
        check("rst_err", {31'b0, Cmd_Err}, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        idle(1);

        // write then read back (write frame followed back-to-back by read)
        wr_frame(8'h05, 8'h3C);
        rd_frame(8'h05, 1'b0);
        idle(3);

        // unknown opcode, then a write immediately after
        bad_byte(8'h12);
        wr_frame(8'h02, 8'h7E);
        idle(1);

        // read with the transmitter busy; a byte dropped while waiting
        TX_Busy = 1'b1;
        rd_frame(8'h02, 1'b1);
        idle(2);
        bad_byte(8'h55);
        repeat (8) begin
            check("busy_txdata_hold", {24'b0, TX_P_Data}, 32'h7E);
            check("busy_no_txvld", {31'b0, TX_D_VLD}, 0);
            idle(1);
        end
        TX_Busy = 1'b0;
        m = cyc;
        tx_q.push_back(mk(8'h00, 8'h7E, m + 1));
        idle(3);

        // upper address bits ignored; stale read-valid across RdEn
        wr_frame(8'h2F, 8'hA5);
        hold = 1'b1;
        rd_frame(8'h05, 1'b0);
        idle(3);
        rd_frame(8'h1F, 1'b0);
        idle(3);
        hold = 1'b0;
        idle(2);

        // reset mid write frame; next byte is decoded as an opcode
        send_byte(8'hAA);
        send_byte(8'h03);
        RST = 1'b0;
        #1;
        check("midrst_address", {28'b0, Address}, 0);
        check("midrst_wren", {31'b0, WrEn}, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b1;
        bad_byte(8'h3C);
        idle(4);

        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);
        check("err_q_empty", err_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
